// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file:
// CSR addresses, bit positions, cause codes and Zicsr ops.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;

  localparam int MIE_BIT        = 3;
  localparam int MPIE_BIT       = 7;
  localparam int MPP_LO         = 11;
  localparam int MPP_HI         = 12;
  localparam int MTIX           = 7;
  localparam int MEIX           = 11;
  localparam int LOCAL_IRQ_BASE = 16;

  localparam logic [31:0] CAUSE_TIMER    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT_BASE = 32'h8000_0010;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Interrupt priority encoder: lowest external line
// first, timer last; reports the mcause to take.
module irq_prio_enc
  import csr_pkg::*;
#(
  parameter int NUM_EXT_IRQ = 2
) (
  input  logic [NUM_EXT_IRQ-1:0] ext_pend_i,
  input  logic                   tmr_pend_i,
  output logic                   valid_o,
  output logic [31:0]            cause_o
);

  // Scan high to low so the lowest pending line wins.
  always_comb begin
    valid_o = (|ext_pend_i) | tmr_pend_i;
    cause_o = tmr_pend_i ? CAUSE_TIMER : 32'h0;
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
      if (ext_pend_i[i]) begin
        cause_o = CAUSE_EXT_BASE + 32'(i);
      end
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file, interrupt entry/return
// and wfi hold for the pipelined RV32 core.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int          NUM_EXT_IRQ = 2,
  parameter logic [31:0] RESET_TVEC  = 32'h0001_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             csr_op,
  input  logic [11:0]            csr_addr,
  input  logic                   csr_valid,
  input  logic [31:0]            rs1_data,
  input  logic [4:0]             zimm,
  input  logic                   is_mret,
  input  logic                   is_wfi,
  input  logic [31:0]            pc,
  input  logic                   retire,
  input  logic                   stall,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq,
  input  logic                   timer_irq,
  output logic [31:0]            csr_rdata,
  output logic                   trap_take,
  output logic [31:0]            trap_pc,
  output logic                   ret_take,
  output logic [31:0]            ret_pc,
  output logic                   wfi_stall
);

  localparam logic [31:0] ONE = 32'd1;
  localparam logic [31:0] LINE_MASK =
    ((ONE << NUM_EXT_IRQ) - ONE) << LOCAL_IRQ_BASE;
  localparam logic [31:0] MIE_MASK =
    LINE_MASK | (ONE << MTIX) | (ONE << MEIX);
  localparam logic [31:0] EPC_MASK = 32'hFFFF_FFFC;

  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [29:0] base_q, base_d;
  logic        mode_q, mode_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic        wfi_q, wfi_d;

  logic [31:0] mip;
  logic [31:0] pending;
  logic [31:0] mstatus;
  logic [31:0] rdata;
  logic [31:0] src;
  logic [31:0] wdata;
  logic        do_wr;
  logic        wr_en;
  logic        irq_valid;
  logic [31:0] irq_cause;
  logic [31:0] base32;

  // Live interrupt lines and the enabled subset.
  always_comb begin
    mip = 32'h0;
    mip[MTIX] = timer_irq;
    mip[MEIX] = |ext_irq;
    mip[LOCAL_IRQ_BASE +: NUM_EXT_IRQ] = ext_irq;
    pending = mip & mie_q;
  end

  // The MEIP aggregate never fires alone: only
  // line bits and the timer feed the encoder.
  irq_prio_enc #(
    .NUM_EXT_IRQ(NUM_EXT_IRQ)
  ) u_prio (
    .ext_pend_i(pending[LOCAL_IRQ_BASE +: NUM_EXT_IRQ]),
    .tmr_pend_i(pending[MTIX]),
    .valid_o   (irq_valid),
    .cause_o   (irq_cause)
  );

  // Old-value read mux.
  always_comb begin
    mstatus = 32'h0;
    mstatus[MPP_HI:MPP_LO] = 2'b11;
    mstatus[MPIE_BIT] = mst_mpie_q;
    mstatus[MIE_BIT] = mst_mie_q;
    case (csr_addr)
      ADDR_MSTATUS:  rdata = mstatus;
      ADDR_MIE:      rdata = mie_q;
      ADDR_MTVEC:    rdata = {base_q, 1'b0, mode_q};
      ADDR_MEPC:     rdata = mepc_q;
      ADDR_MCAUSE:   rdata = mcause_q;
      ADDR_MIP:      rdata = mip;
      ADDR_MCYCLE:   rdata = mcycle_q[31:0];
      ADDR_MCYCLEH:  rdata = mcycle_q[63:32];
      ADDR_MINSTRET: rdata = minstret_q[31:0];
      ADDR_MINSTRH:  rdata = minstret_q[63:32];
      default:       rdata = 32'h0;
    endcase
  end

  // Zicsr write value; set/clear with zero source skip.
  always_comb begin
    src = csr_op[2] ? {27'h0, zimm} : rs1_data;
    wdata = rdata;
    do_wr = 1'b0;
    unique case (csr_op)
      CSR_RW, CSR_RWI: begin
        wdata = src;
        do_wr = 1'b1;
      end
      CSR_RS, CSR_RSI: begin
        wdata = rdata | src;
        do_wr = |src;
      end
      CSR_RC, CSR_RCI: begin
        wdata = rdata & ~src;
        do_wr = |src;
      end
      default: ;
    endcase
  end

  // Trap, return and handler target.
  always_comb begin
    trap_take = mst_mie_q & irq_valid & ~stall;
    ret_take  = is_mret & ~stall & ~trap_take;
    wr_en     = csr_valid & do_wr & ~stall & ~trap_take;
    base32    = {base_q, 2'b00};
    trap_pc   = mode_q
              ? base32 + {25'h0, irq_cause[4:0], 2'b00}
              : base32;
    ret_pc    = mepc_q;
    csr_rdata = rdata;
    wfi_stall = wfi_q;
  end

  // Next-state: trap beats mret beats CSR write.
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    base_d     = base_q;
    mode_d     = mode_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    wfi_d      = wfi_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q
               + {63'h0, retire & ~stall};
    if (trap_take) begin
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      mepc_d     = (wfi_q ? pc + 32'd4 : pc)
                 & EPC_MASK;
      mcause_d   = irq_cause;
    end else if (ret_take) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mst_mie_d  = wdata[MIE_BIT];
          mst_mpie_d = wdata[MPIE_BIT];
        end
        ADDR_MIE:      mie_d = wdata & MIE_MASK;
        ADDR_MTVEC: begin
          base_d = wdata[31:2];
          if (!wdata[1]) mode_d = wdata[0];
        end
        ADDR_MEPC:     mepc_d = wdata & EPC_MASK;
        ADDR_MCAUSE:   mcause_d = wdata;
        ADDR_MCYCLE:   mcycle_d[31:0] = wdata;
        ADDR_MCYCLEH:  mcycle_d[63:32] = wdata;
        ADDR_MINSTRET: minstret_d[31:0] = wdata;
        ADDR_MINSTRH:  minstret_d[63:32] = wdata;
        default: ;
      endcase
    end
    if (wfi_q) begin
      if (irq_valid) wfi_d = 1'b0;
    end else if (is_wfi && !stall && !irq_valid) begin
      wfi_d = 1'b1;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= 32'h0;
      base_q     <= RESET_TVEC[31:2];
      mode_q     <= RESET_TVEC[0];
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
      wfi_q      <= 1'b0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      base_q     <= base_d;
      mode_q     <= mode_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      wfi_q      <= wfi_d;
    end
  end

endmodule
